bit_skip_scheduler: RTL and testbench
=====================================

# bit_skip_scheduler

Sequential zero-bit-skipping scheduler for the bit-serial datapath. Accepts one 5-bit essential-bit mask per operand over a valid/ready handshake and emits the positions of its set bits one per cycle, MSB first, clearing each bit as it is consumed. Each position drives the shift amount of the downstream bit-serial accumulate stage; an all-zero mask produces a single "zero" beat so operand accounting stays aligned. Sits between the operand bitmask generator and the shift-accumulate lane.

## Interface
- TAG_W, default 8: width of the sideband tag carried with each mask (operand/lane ID).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream mask valid.
- in_ready  out  1  scheduler can accept a mask this cycle.
- in_mask  in  5  essential-bit mask; bit 4 is the MSB.
- in_tag  in  TAG_W  sideband tag, returned unchanged on every beat of that mask.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_pos  out  3  MSB-first position of the highest remaining set bit.
- out_idx  out  3  beat index within the current mask, 0..4.
- out_last  out  1  final beat of the current mask.
- out_zero  out  1  beat stands for an all-zero mask; no shift-accumulate.
- out_tag  out  TAG_W  tag of the mask being serialized.
- busy  out  1  equals out_valid.

## Operation
- State: active flag; rem[4:0], the bits not yet emitted; zf, the zero-mask flag; tag_q; idx_q[2:0].
- Encoding, combinational from rem: highest set bit b maps to out_pos = 4-b. Bit 4 gives 0, bit 3 gives 1, bit 2 gives 2, bit 1 gives 3, bit 0 gives 4. rem == 0 gives 0.
- out_valid = active.
- out_last = zf OR (rem has exactly one set bit).
- out_zero = zf.
- out_idx = idx_q.
- out_tag = tag_q.
- in_ready = !active OR (out_valid AND out_ready AND out_last). A new mask can load in the same cycle the last beat retires.
- Load (in_valid AND in_ready): rem <= in_mask, zf <= (in_mask == 0), tag_q <= in_tag, idx_q <= 0, active <= 1.
- Beat retire without last: clear the highest set bit of rem; idx_q <= idx_q+1; tag_q and zf hold.
- Last beat retires with no load in that cycle: active <= 0, rem <= 0, zf <= 0, idx_q <= 0. tag_q holds its value.
- Stall (out_valid AND NOT out_ready): all state and outputs hold stable. in_ready = 0.
- in_valid while in_ready = 0: input ignored. Upstream must hold the input.
- The number of beats per mask is max(popcount(in_mask), 1).

## Timing
- Reset (async assert): active, rem, zf, idx_q = 0 and tag_q = 0 immediately. Outputs are then out_valid=0, out_pos=0, out_idx=0, out_last=0, out_zero=0, out_tag=0, busy=0, in_ready=1.
- Reset mid-mask discards the remaining bits. No residual beats appear after release.
- Latency: a mask accepted at edge N produces its first beat valid in cycle N+1.
- Throughput: with out_ready held high, one beat per cycle and no bubble between consecutive masks.
- Simultaneous last-beat retire and new load: the load wins. active stays 1, and the next cycle shows beat 0 of the new mask.
- out_* are functions of registers only. There is no combinational path from in_* to out_*.
- in_ready depends combinationally on out_ready.

## Test plan
- Reset, then load mask 5'b10110 with tag 0x3C and out_ready=1 -> beats (pos, idx) = (0,0), (2,1), (3,2). out_last is set only on the third beat. out_tag=0x3C on every beat. in_ready=1 in the third-beat cycle.
- Load mask 5'b00000 with tag 0x11 -> a single beat with out_zero=1, out_last=1, out_pos=0, out_idx=0, out_tag=0x11. Next cycle out_valid=0.
- Back-to-back loads 5'b00001 then 5'b11111 with in_valid and out_ready held high -> pos 4 (last), then pos 0, 1, 2, 3, 4 in consecutive cycles. No idle cycle.
- Load 5'b01010, hold out_ready=0 for 3 cycles -> pos=1, idx=0, in_ready=0 stable for all 3 cycles. After release: pos=3, idx=1, last=1.
- Load 5'b11111, assert reset after 2 retired beats -> all outputs go to 0 asynchronously and in_ready=1. After deassert, out_valid stays 0 until the next load.

Source files
------------

// File: rtl/bit_skip_scheduler.sv
// bit_skip_scheduler
// Serializes a 5-bit essential-bit mask into one beat per set bit, MSB first.
// Each beat carries the MSB-first position of the highest remaining bit; an
// all-zero mask yields a single "zero" beat so operand accounting stays aligned.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready may depend combinationally on out_ready, because a new mask
// can load in the same cycle the last beat of the previous mask retires.
// out_* depend on registers only. While out_valid is high and out_ready is low,
// every output holds.
module bit_skip_scheduler #(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_mask,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_pos,
    output logic [2:0]       out_idx,
    output logic             out_last,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    logic             active_q, active_d;
    logic [4:0]       rem_q, rem_d;
    logic             zf_q, zf_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [2:0]       idx_q, idx_d;

    logic [2:0] pos;
    logic       single_bit;
    logic       last;
    logic       retire;
    logic       load;

    // Priority-encode the highest remaining bit into an MSB-first position.
    always_comb begin
        pos = 3'd0;
        if (rem_q[4])      pos = 3'd0;
        else if (rem_q[3]) pos = 3'd1;
        else if (rem_q[2]) pos = 3'd2;
        else if (rem_q[1]) pos = 3'd3;
        else if (rem_q[0]) pos = 3'd4;
    end

    assign single_bit = (rem_q != 5'd0) && ((rem_q & (rem_q - 5'd1)) == 5'd0);
    assign last       = zf_q | single_bit;
    assign retire     = active_q & out_ready;
    assign in_ready   = ~active_q | (retire & last);
    assign load       = in_valid & in_ready;

    assign out_valid = active_q;
    assign out_pos   = pos;
    assign out_idx   = idx_q;
    assign out_last  = active_q & last;
    assign out_zero  = zf_q;
    assign out_tag   = tag_q;
    assign busy      = active_q;

    // Next-state: a load wins over a retiring last beat; otherwise retire
    // either consumes the top bit or returns the scheduler to idle.
    always_comb begin
        active_d = active_q;
        rem_d    = rem_q;
        zf_d     = zf_q;
        tag_d    = tag_q;
        idx_d    = idx_q;
        if (load) begin
            active_d = 1'b1;
            rem_d    = in_mask;
            zf_d     = (in_mask == 5'd0);
            tag_d    = in_tag;
            idx_d    = 3'd0;
        end else if (retire) begin
            if (last) begin
                active_d = 1'b0;
                rem_d    = 5'd0;
                zf_d     = 1'b0;
                idx_d    = 3'd0;
            end else begin
                rem_d = rem_q & ~(5'b10000 >> pos);
                idx_d = idx_q + 3'd1;
            end
        end
    end

    // State registers; reset discards any mask in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            rem_q    <= 5'd0;
            zf_q     <= 1'b0;
            tag_q    <= '0;
            idx_q    <= 3'd0;
        end else begin
            active_q <= active_d;
            rem_q    <= rem_d;
            zf_q     <= zf_d;
            tag_q    <= tag_d;
            idx_q    <= idx_d;
        end
    end

endmodule

// File: tb/tb_bit_skip_scheduler.sv
// Testbench for bit_skip_scheduler: directed scenarios plus a randomized
// stream checked against a beat-list reference model.
module tb_bit_skip_scheduler;

  localparam int TAG_W = 8;
  localparam int EW    = 8 + TAG_W;   // {pos, idx, last, zero, tag}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [4:0]       in_mask = 5'd0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2:0]       out_pos;
  logic [2:0]       out_idx;
  logic             out_last;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  bit_skip_scheduler #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pos   (out_pos),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_zero  (out_zero),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  logic [EW:0] obs;
  assign obs = {out_valid, out_pos, out_idx, out_last, out_zero, out_tag};

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // Expected beats of the mask currently being serialized.
  logic [EW-1:0] exp_q[$];

  function automatic void push_mask(input logic [4:0] mask, input logic [TAG_W-1:0] tag);
    int n;
    int k;
    n = 0;
    for (int b = 0; b < 5; b++) if (mask[b]) n++;
    if (n == 0) begin
      exp_q.push_back({3'd0, 3'd0, 1'b1, 1'b1, tag});
    end else begin
      k = 0;
      for (int b = 4; b >= 0; b--) begin
        if (mask[b]) begin
          exp_q.push_back({3'(4 - b), 3'(k), (k == n - 1), 1'b0, tag});
          k++;
        end
      end
    end
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [4:0] m, input logic [TAG_W-1:0] t,
                       input logic rdy);
    @(negedge clk);
    in_valid  = v;
    in_mask   = m;
    in_tag    = t;
    out_ready = rdy;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0);
    n_cmp++;
    if (obs !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got obs=%h busy=%b, want obs=0 busy=0", obs, busy);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 5'd0, '0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_idle: got valid=%b ready=%b, want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    logic [EW:0] want [3];
    logic        rdy_want [3];
    want[0] = {1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 8'h3C};
    want[1] = {1'b1, 3'd2, 3'd1, 1'b0, 1'b0, 8'h3C};
    want[2] = {1'b1, 3'd3, 3'd2, 1'b1, 1'b0, 8'h3C};
    rdy_want[0] = 1'b0;
    rdy_want[1] = 1'b0;
    rdy_want[2] = 1'b1;
    drive(1'b1, 5'b10110, 8'h3C, 1'b1);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_load_ready: got %b, want 1", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, '0, 1'b1);
      n_cmp++;
      if (obs !== want[i]) begin
        n_err++;
        $display("FAIL basic_beat%0d: got %h, want %h", i, obs, want[i]);
      end
      n_cmp++;
      if (in_ready !== rdy_want[i]) begin
        n_err++;
        $display("FAIL basic_in_ready%0d: got %b, want %b", i, in_ready, rdy_want[i]);
      end
    end
    drive(1'b0, 5'd0, '0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_idle_after: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_zero_mask();
    drive(1'b1, 5'b00000, 8'h11, 1'b1);
    drive(1'b0, 5'd0, '0, 1'b1);
    n_cmp++;
    if (obs !== {1'b1, 3'd0, 3'd0, 1'b1, 1'b1, 8'h11}) begin
      n_err++;
      $display("FAIL zero_beat: got %h, want %h", obs, {1'b1, 3'd0, 3'd0, 1'b1, 1'b1, 8'h11});
    end
    drive(1'b0, 5'd0, '0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0 || out_zero !== 1'b0) begin
      n_err++;
      $display("FAIL zero_after: got valid=%b zero=%b, want 0/0", out_valid, out_zero);
    end
  endtask

  task automatic test_back_to_back();
    logic [EW:0] want;
    drive(1'b1, 5'b00001, 8'hA1, 1'b1);
    drive(1'b1, 5'b11111, 8'hB2, 1'b1);
    n_cmp++;
    if (obs !== {1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 8'hA1} || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first: got %h ready=%b, want %h ready=1", obs, in_ready,
               {1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 8'hA1});
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 5'd0, '0, 1'b1);
      want = {1'b1, 3'(i), 3'(i), (i == 4), 1'b0, 8'hB2};
      n_cmp++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL b2b_second_beat%0d: got %h, want %h", i, obs, want);
      end
    end
    drive(1'b0, 5'd0, '0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle_after: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 5'b01010, 8'h5A, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, '0, 1'b0);
      n_cmp++;
      if (obs !== {1'b1, 3'd1, 3'd0, 1'b0, 1'b0, 8'h5A} || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_cycle%0d: got %h ready=%b, want %h ready=0", i, obs, in_ready,
                 {1'b1, 3'd1, 3'd0, 1'b0, 1'b0, 8'h5A});
      end
    end
    drive(1'b0, 5'd0, '0, 1'b1);
    drive(1'b0, 5'd0, '0, 1'b1);
    n_cmp++;
    if (obs !== {1'b1, 3'd3, 3'd1, 1'b1, 1'b0, 8'h5A}) begin
      n_err++;
      $display("FAIL stall_release: got %h, want %h", obs, {1'b1, 3'd3, 3'd1, 1'b1, 1'b0, 8'h5A});
    end
    drive(1'b0, 5'd0, '0, 1'b1);
  endtask

  task automatic test_reset_mid_mask();
    drive(1'b1, 5'b11111, 8'h77, 1'b1);
    drive(1'b0, 5'd0, '0, 1'b1);
    drive(1'b0, 5'd0, '0, 1'b1);
    drive(1'b0, 5'd0, '0, 1'b1);
    n_cmp++;
    if (obs !== {1'b1, 3'd2, 3'd2, 1'b0, 1'b0, 8'h77}) begin
      n_err++;
      $display("FAIL midreset_pre: got %h, want %h", obs, {1'b1, 3'd2, 3'd2, 1'b0, 1'b0, 8'h77});
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_async: got %h ready=%b, want 0 ready=1", obs, in_ready);
    end
    drive(1'b0, 5'd0, '0, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, '0, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midreset_residual%0d: got valid=%b, want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_random_stream();
    logic             have_pend;
    logic [4:0]       p_mask;
    logic [TAG_W-1:0] p_tag;
    logic             exp_ready;
    logic             v;
    logic             rdy;
    have_pend = 1'b0;
    p_mask    = 5'd0;
    p_tag     = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!have_pend && cyc < 580 && $urandom_range(0, 3) != 0) begin
        have_pend = 1'b1;
        p_mask    = 5'($urandom_range(0, 31));
        p_tag     = TAG_W'($urandom);
      end
      v   = have_pend;
      rdy = ($urandom_range(0, 3) != 0);
      drive(v, p_mask, p_tag, rdy);
      exp_ready = (exp_q.size() == 0) || (rdy && exp_q.size() == 1);
      n_cmp++;
      if (exp_q.size() != 0) begin
        if (obs !== {1'b1, exp_q[0]}) begin
          n_err++;
          $display("FAIL rand_beat cyc=%0d: got %h, want %h", cyc, obs, {1'b1, exp_q[0]});
        end
      end else if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rand_idle cyc=%0d: got valid=%b, want 0", cyc, out_valid);
      end
      n_cmp++;
      if (in_ready !== exp_ready) begin
        n_err++;
        $display("FAIL rand_in_ready cyc=%0d: got %b, want %b", cyc, in_ready, exp_ready);
      end
      if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
      if (v && exp_ready) begin
        push_mask(p_mask, p_tag);
        have_pend = 1'b0;
      end
    end
    drive(1'b0, 5'd0, '0, 1'b1);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_zero_mask();
    test_back_to_back();
    test_stall();
    test_reset_mid_mask();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
